// File: rtl/mips_multicycle.sv
// rtl/mips_multicycle.sv - multicycle MIPS-subset core with one shared memory port
// Optional bne support when MIPS_MC_BNE_EN is defined.
module mips_multicycle #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int          ADDR_W   = 32,
    parameter int          TEST_REG = 2
) (
    input  logic              clk,
    input  logic              reset,
    output logic              mem_req,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [31:0]       mem_wdata,
    input  logic              mem_ready,
    input  logic [31:0]       mem_rdata,
    output logic              illegal_op,
    output logic [15:0]       test_value
);
    localparam logic [5:0] OP_RTYPE = 6'h00, OP_J = 6'h02, OP_BEQ = 6'h04, OP_BNE = 6'h05;
    localparam logic [5:0] OP_ADDI = 6'h08, OP_LW = 6'h23, OP_SW = 6'h2B;

    typedef enum logic [3:0] {
        S_IDLE, S_FETCH, S_DECODE, S_MEMADR, S_MEMRD, S_MEMWB, S_MEMWR,
        S_EXEC, S_ALUWB, S_ADDIEX, S_ADDIWB, S_BRANCH, S_JUMP
    } state_t;

    state_t      state, next_state;
    logic [31:0] pc, ir, mdr, a, b, aluout;
    logic [31:0] regs [32];

    logic [5:0]  op, funct;
    logic [4:0]  rs, rt, rd;
    logic [31:0] signimm, alu_r, addr_full;
    logic        funct_ok, take;
    logic        rf_we;
    logic [4:0]  rf_wa;
    logic [31:0] rf_wd;

    assign op      = ir[31:26];
    assign rs      = ir[25:21];
    assign rt      = ir[20:16];
    assign rd      = ir[15:11];
    assign funct   = ir[5:0];
    assign signimm = {{16{ir[15]}}, ir[15:0]};

    always_comb begin
        alu_r    = '0;
        funct_ok = 1'b1;
        case (funct)
            6'h20:   alu_r = a + b;
            6'h22:   alu_r = a - b;
            6'h24:   alu_r = a & b;
            6'h25:   alu_r = a | b;
            6'h2A:   alu_r = {31'b0, $signed(a) < $signed(b)};
            default: funct_ok = 1'b0;
        endcase
    end

`ifdef MIPS_MC_BNE_EN
    assign take = (op == OP_BNE) ? (a != b) : (a == b);
`else
    assign take = (a == b);
`endif

    // Data accesses use the address computed in MEMADR; everything else points at PC.
    assign addr_full  = (state == S_MEMRD || state == S_MEMWR) ? aluout : pc;
    assign mem_addr   = addr_full[ADDR_W-1:0];
    assign mem_wdata  = (state == S_MEMWR) ? b : 32'h0;
    assign test_value = regs[TEST_REG][15:0];

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state <= S_IDLE;
        else        state <= next_state;
    end

    always_comb begin
        next_state = state;
        mem_req    = 1'b0;
        mem_we     = 1'b0;
        illegal_op = 1'b0;
        case (state)
            S_IDLE:  next_state = S_FETCH;
            S_FETCH: begin
                mem_req = 1'b1;
                if (mem_ready) next_state = S_DECODE;
            end
            S_DECODE: begin
                case (op)
                    OP_LW, OP_SW: next_state = S_MEMADR;
                    OP_RTYPE: begin
                        if (funct_ok) next_state = S_EXEC;
                        else begin
                            illegal_op = 1'b1;
                            next_state = S_FETCH;
                        end
                    end
                    OP_BEQ:  next_state = S_BRANCH;
`ifdef MIPS_MC_BNE_EN
                    OP_BNE:  next_state = S_BRANCH;
`endif
                    OP_ADDI: next_state = S_ADDIEX;
                    OP_J:    next_state = S_JUMP;
                    default: begin
                        illegal_op = 1'b1;
                        next_state = S_FETCH;
                    end
                endcase
            end
            S_MEMADR: next_state = (op == OP_LW) ? S_MEMRD : S_MEMWR;
            S_MEMRD: begin
                mem_req = 1'b1;
                if (mem_ready) next_state = S_MEMWB;
            end
            S_MEMWR: begin
                mem_req = 1'b1;
                mem_we  = 1'b1;
                if (mem_ready) next_state = S_FETCH;
            end
            S_EXEC:   next_state = S_ALUWB;
            S_ADDIEX: next_state = S_ADDIWB;
            S_MEMWB, S_ALUWB, S_ADDIWB, S_BRANCH, S_JUMP: next_state = S_FETCH;
            default:  next_state = S_IDLE;
        endcase
    end

    always_comb begin
        rf_we = 1'b0;
        rf_wa = rt;
        rf_wd = aluout;
        case (state)
            S_MEMWB: begin rf_we = 1'b1; rf_wd = mdr; end
            S_ALUWB: begin rf_we = 1'b1; rf_wa = rd; end
            S_ADDIWB: rf_we = 1'b1;
            default: ;
        endcase
    end

    // $0 is never written, so reading it always yields zero.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < 32; i++) regs[i] <= '0;
        end else if (rf_we && rf_wa != 5'd0) begin
            regs[rf_wa] <= rf_wd;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            pc     <= RESET_PC;
            ir     <= '0;
            mdr    <= '0;
            a      <= '0;
            b      <= '0;
            aluout <= '0;
        end else begin
            case (state)
                S_FETCH: if (mem_ready) begin
                    ir <= mem_rdata;
                    pc <= pc + 32'd4;
                end
                S_DECODE: begin
                    a      <= regs[rs];
                    b      <= regs[rt];
                    aluout <= pc + (signimm << 2);
                end
                S_MEMADR, S_ADDIEX: aluout <= a + signimm;
                S_MEMRD:  if (mem_ready) mdr <= mem_rdata;
                S_EXEC:   aluout <= alu_r;
                S_BRANCH: if (take) pc <= aluout;
                S_JUMP:   pc <= {pc[31:28], ir[25:0], 2'b00};
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_mips_multicycle.sv
// tb/tb_mips_multicycle.sv - randomized self-checking bench for mips_multicycle
// Memory is modelled by the bench; expected results come from an ISA-level interpreter.
module tb_mips_multicycle;
    logic        clk, reset, mem_req, mem_we, mem_ready, illegal_op;
    logic [31:0] mem_addr, mem_wdata, mem_rdata;
    logic [15:0] test_value;

    mips_multicycle dut (
        .clk(clk), .reset(reset), .mem_req(mem_req), .mem_we(mem_we),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_ready(mem_ready),
        .mem_rdata(mem_rdata), .illegal_op(illegal_op), .test_value(test_value)
    );

    localparam logic [31:0] HALT = 32'h1000_FFFF;

    logic [31:0] mem   [1024];
    logic [31:0] m_mem [1024];
    logic [31:0] m_regs[32];
    int          fetch_cyc[1024];

    int n_checks = 0, n_pass = 0;
    int cyc, fetch_wait, data_wait, wait_left, stab_err, illegal_hi, write_cnt;
    int halt_seen, first_halt_cyc, prev_halt_cyc, halt_period;
    bit in_xfer, stall_all;
    logic [31:0] data_base, cur_halt, s_addr, s_wdata, last_waddr, last_wdata;
    logic        s_we;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    function automatic logic [31:0] enc_i(input logic [5:0] op, input logic [4:0] rs,
                                          input logic [4:0] rt, input logic [15:0] imm);
        return {op, rs, rt, imm};
    endfunction

    function automatic logic [31:0] enc_r(input logic [4:0] rs, input logic [4:0] rt,
                                          input logic [4:0] rd, input logic [5:0] fn);
        return {6'h00, rs, rt, rd, 5'h00, fn};
    endfunction

    task automatic clear_mem();
        for (int i = 0; i < 1024; i++) mem[i] = 32'h0;
    endtask

    // One clock of memory behaviour, observed and driven at the falling edge.
    task automatic tick();
        logic [9:0] idx;
        bit is_data;
        @(negedge clk);
        cyc++;
        if (illegal_op) illegal_hi++;
        idx = mem_addr[11:2];
        if (mem_req) begin
            is_data = (mem_addr >= data_base);
            if (!in_xfer) begin
                in_xfer   = 1'b1;
                wait_left = is_data ? data_wait : fetch_wait;
                if (!is_data && !mem_we) begin
                    if (mem_addr == cur_halt) begin
                        halt_seen++;
                        if (halt_seen == 1) first_halt_cyc = cyc;
                        else halt_period = cyc - prev_halt_cyc;
                        prev_halt_cyc = cyc;
                    end
                    fetch_cyc[idx] = cyc;
                end
            end else if (mem_addr !== s_addr || mem_we !== s_we || mem_wdata !== s_wdata) begin
                stab_err++;
            end
            s_addr = mem_addr; s_we = mem_we; s_wdata = mem_wdata;
            mem_rdata = mem[idx];
            if (stall_all || wait_left != 0) begin
                mem_ready = 1'b0;
                if (wait_left != 0) wait_left--;
            end else begin
                mem_ready = 1'b1;
                in_xfer   = 1'b0;
                if (mem_we) begin
                    mem[idx]   = mem_wdata;
                    write_cnt++;
                    last_waddr = mem_addr;
                    last_wdata = mem_wdata;
                end
            end
        end else begin
            in_xfer   = 1'b0;
            mem_ready = 1'($urandom_range(0, 1));
            mem_rdata = $urandom;
        end
    endtask

    task automatic do_reset();
        reset = 1'b0;
        in_xfer = 1'b0; mem_ready = 1'b0; stall_all = 1'b0;
        cyc = 0; stab_err = 0; illegal_hi = 0; write_cnt = 0;
        halt_seen = 0; first_halt_cyc = 0; prev_halt_cyc = 0; halt_period = 0;
        for (int i = 0; i < 1024; i++) fetch_cyc[i] = -1;
        repeat (2) @(negedge clk);
        reset = 1'b1;
    endtask

    task automatic run(input logic [31:0] halt, input int hits, input int budget, output bit ok);
        cur_halt = halt;
        ok = 1'b0;
        for (int i = 0; i < budget; i++) begin
            tick();
            if (halt_seen >= hits) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    // Instruction-set interpreter over m_mem/m_regs; returns expected cycles up to the halt fetch.
    task automatic model_run(input logic [31:0] halt, output int cy, output logic [15:0] tv);
        logic [31:0] pc, ins, npc, imm, rsv, rtv, res, addr;
        logic [4:0]  dst;
        bit          wr;
        int          c;
        cy = 0;
        pc = 32'h0;
        for (int n = 0; n < 5000 && pc != halt; n++) begin
            ins = m_mem[pc[11:2]];
            npc = pc + 32'd4;
            rsv = m_regs[ins[25:21]];
            rtv = m_regs[ins[20:16]];
            imm = {{16{ins[15]}}, ins[15:0]};
            addr = rsv + imm;
            wr = 1'b0; dst = ins[20:16]; res = 32'h0; c = 2;
            case (ins[31:26])
                6'h00: begin
                    wr = 1'b1; dst = ins[15:11]; c = 4;
                    case (ins[5:0])
                        6'h20: res = rsv + rtv;
                        6'h22: res = rsv - rtv;
                        6'h24: res = rsv & rtv;
                        6'h25: res = rsv | rtv;
                        6'h2A: res = ($signed(rsv) < $signed(rtv)) ? 32'd1 : 32'd0;
                        default: begin wr = 1'b0; c = 2; end
                    endcase
                end
                6'h08: begin wr = 1'b1; res = addr; c = 4; end
                6'h23: begin wr = 1'b1; res = m_mem[addr[11:2]]; c = 5 + data_wait; end
                6'h2B: begin m_mem[addr[11:2]] = rtv; c = 4 + data_wait; end
                6'h04: begin c = 3; if (rsv == rtv) npc = npc + (imm << 2); end
`ifdef MIPS_MC_BNE_EN
                6'h05: begin c = 3; if (rsv != rtv) npc = npc + (imm << 2); end
`endif
                6'h02: begin c = 3; npc = {npc[31:28], ins[25:0], 2'b00}; end
                default: c = 2;
            endcase
            if (wr && dst != 5'd0) m_regs[dst] = res;
            cy += c + fetch_wait;
            pc = npc;
        end
        tv = m_regs[2][15:0];
    endtask

    task automatic test_reset();
        clear_mem();
        mem[0] = HALT;
        fetch_wait = 0; data_wait = 0; data_base = 32'hFFFF_FFFF; cur_halt = 32'hFFFF_FFFF;
        stall_all = 1'b1; in_xfer = 1'b0;
        @(negedge clk);
        n_checks++; if (mem_req !== 1'b0) $display("FAIL rst_req: got %b expected 0", mem_req); else n_pass++;
        n_checks++; if (mem_we !== 1'b0) $display("FAIL rst_we: got %b expected 0", mem_we); else n_pass++;
        n_checks++; if (mem_addr !== 32'h0) $display("FAIL rst_addr: got %h expected 0", mem_addr); else n_pass++;
        n_checks++; if (mem_wdata !== 32'h0) $display("FAIL rst_wdata: got %h expected 0", mem_wdata); else n_pass++;
        n_checks++; if (illegal_op !== 1'b0) $display("FAIL rst_illegal: got %b expected 0", illegal_op); else n_pass++;
        n_checks++; if (test_value !== 16'h0) $display("FAIL rst_tv: got %h expected 0", test_value); else n_pass++;
        reset = 1'b1;
        #1;
        n_checks++; if (mem_req !== 1'b0) $display("FAIL idle_req: got %b expected 0", mem_req); else n_pass++;
        tick();
        n_checks++; if (mem_req !== 1'b1 || mem_addr !== 32'h0) $display("FAIL first_fetch: got req=%b addr=%h expected req=1 addr=0", mem_req, mem_addr); else n_pass++;
        repeat (3) tick();
        n_checks++; if (mem_req !== 1'b1) $display("FAIL fetch_hold: got %b expected 1", mem_req); else n_pass++;
        #2 reset = 1'b0;
        in_xfer = 1'b0;
        #1;
        n_checks++; if (mem_req !== 1'b0) $display("FAIL async_drop: got %b expected 0", mem_req); else n_pass++;
        @(negedge clk);
        reset = 1'b1;
        stall_all = 1'b0;
        #1;
        n_checks++; if (mem_req !== 1'b0) $display("FAIL idle_after_rst: got %b expected 0", mem_req); else n_pass++;
        tick();
        n_checks++; if (mem_req !== 1'b1 || mem_addr !== 32'h0) $display("FAIL refetch: got req=%b addr=%h expected req=1 addr=0", mem_req, mem_addr); else n_pass++;
    endtask

    task automatic test_addi_add();
        bit ok;
        clear_mem();
        mem[0] = enc_i(6'h08, 5'd0, 5'd2, 16'd5);
        mem[1] = enc_i(6'h08, 5'd0, 5'd3, 16'd7);
        mem[2] = enc_r(5'd2, 5'd3, 5'd2, 6'h20);
        mem[3] = HALT;
        fetch_wait = 0; data_wait = 0; data_base = 32'hFFFF_FFFF;
        do_reset();
        run(32'h0C, 1, 100, ok);
        n_checks++; if (!ok) $display("FAIL add_timeout: got no halt fetch expected one"); else n_pass++;
        n_checks++; if (fetch_cyc[3] - fetch_cyc[0] !== 12) $display("FAIL add_cycles: got %0d expected 12", fetch_cyc[3] - fetch_cyc[0]); else n_pass++;
        n_checks++; if (test_value !== 16'd12) $display("FAIL add_tv: got %0d expected 12", test_value); else n_pass++;
    endtask

    task automatic test_mem_wait();
        bit ok;
        clear_mem();
        mem[0] = enc_i(6'h08, 5'd0, 5'd2, 16'd12);
        mem[1] = enc_i(6'h2B, 5'd0, 5'd2, 16'h0040);
        mem[2] = enc_i(6'h23, 5'd0, 5'd4, 16'h0040);
        mem[3] = enc_i(6'h08, 5'd0, 5'd2, 16'd0);
        mem[4] = enc_r(5'd4, 5'd0, 5'd2, 6'h20);
        mem[5] = HALT;
        fetch_wait = 0; data_wait = 2; data_base = 32'h40;
        do_reset();
        run(32'h14, 1, 200, ok);
        n_checks++; if (!ok) $display("FAIL mem_timeout: got no halt fetch expected one"); else n_pass++;
        n_checks++; if (write_cnt !== 1 || last_waddr !== 32'h40 || last_wdata !== 32'd12)
            $display("FAIL sw_write: got cnt=%0d addr=%h data=%0d expected 1/40/12", write_cnt, last_waddr, last_wdata); else n_pass++;
        n_checks++; if (stab_err !== 0) $display("FAIL hs_stable: got %0d changes expected 0", stab_err); else n_pass++;
        n_checks++; if (fetch_cyc[2] - fetch_cyc[1] !== 6) $display("FAIL sw_cycles: got %0d expected 6", fetch_cyc[2] - fetch_cyc[1]); else n_pass++;
        n_checks++; if (fetch_cyc[3] - fetch_cyc[2] !== 7) $display("FAIL lw_cycles: got %0d expected 7", fetch_cyc[3] - fetch_cyc[2]); else n_pass++;
        n_checks++; if (test_value !== 16'd12) $display("FAIL lw_tv: got %0d expected 12", test_value); else n_pass++;
    endtask

    task automatic test_branch_jump();
        bit ok;
        clear_mem();
        mem[0]   = {6'h02, 26'h100};
        mem[256] = HALT;
        fetch_wait = 0; data_wait = 0; data_base = 32'hFFFF_FFFF;
        do_reset();
        run(32'h400, 3, 200, ok);
        n_checks++; if (!ok) $display("FAIL jb_timeout: got %0d loop fetches expected 3", halt_seen); else n_pass++;
        n_checks++; if (first_halt_cyc - fetch_cyc[0] !== 3) $display("FAIL j_cycles: got %0d expected 3", first_halt_cyc - fetch_cyc[0]); else n_pass++;
        n_checks++; if (halt_period !== 3) $display("FAIL beq_loop: got %0d expected 3", halt_period); else n_pass++;
    endtask

    task automatic test_slt_zero();
        bit ok;
        clear_mem();
        mem[0] = enc_i(6'h08, 5'd0, 5'd5, 16'hFFFF);
        mem[1] = enc_i(6'h08, 5'd0, 5'd6, 16'd1);
        mem[2] = enc_r(5'd5, 5'd6, 5'd2, 6'h2A);
        mem[3] = HALT;
        fetch_wait = 0; data_wait = 0; data_base = 32'hFFFF_FFFF;
        do_reset();
        run(32'h0C, 1, 100, ok);
        n_checks++; if (!ok || test_value !== 16'd1) $display("FAIL slt_tv: got %0d expected 1", test_value); else n_pass++;
        mem[2] = enc_r(5'd6, 5'd6, 5'd0, 6'h20);
        mem[3] = enc_r(5'd0, 5'd6, 5'd2, 6'h20);
        mem[4] = HALT;
        do_reset();
        run(32'h10, 1, 100, ok);
        n_checks++; if (!ok || test_value !== 16'd1) $display("FAIL r0_write: got %0d expected 1", test_value); else n_pass++;
        n_checks++; if (illegal_hi !== 0) $display("FAIL r0_illegal: got %0d expected 0", illegal_hi); else n_pass++;
    endtask

    task automatic test_illegal();
        bit ok;
        int exp_tv, exp_ill, exp_gap, nxt;
`ifdef MIPS_MC_BNE_EN
        exp_tv = 0; exp_ill = 0; exp_gap = 3; nxt = 3;
`else
        exp_tv = 7; exp_ill = 1; exp_gap = 2; nxt = 2;
`endif
        clear_mem();
        mem[0] = enc_i(6'h08, 5'd0, 5'd1, 16'd1);
        mem[1] = enc_i(6'h05, 5'd1, 5'd0, 16'd1);
        mem[2] = enc_i(6'h08, 5'd0, 5'd2, 16'd7);
        mem[3] = HALT;
        fetch_wait = 0; data_wait = 0; data_base = 32'hFFFF_FFFF;
        do_reset();
        run(32'h0C, 1, 100, ok);
        n_checks++; if (!ok || test_value !== 16'(exp_tv)) $display("FAIL bne_tv: got %0d expected %0d", test_value, exp_tv); else n_pass++;
        n_checks++; if (illegal_hi !== exp_ill) $display("FAIL bne_illegal: got %0d expected %0d", illegal_hi, exp_ill); else n_pass++;
        n_checks++; if (fetch_cyc[nxt] - fetch_cyc[1] !== exp_gap) $display("FAIL bne_next: got %0d expected %0d", fetch_cyc[nxt] - fetch_cyc[1], exp_gap); else n_pass++;
        clear_mem();
        mem[0] = enc_i(6'h08, 5'd0, 5'd2, 16'd3);
        mem[1] = enc_r(5'd0, 5'd0, 5'd2, 6'h00);
        mem[2] = HALT;
        do_reset();
        run(32'h08, 1, 100, ok);
        n_checks++; if (!ok || test_value !== 16'd3) $display("FAIL funct_tv: got %0d expected 3", test_value); else n_pass++;
        n_checks++; if (illegal_hi !== 1) $display("FAIL funct_pulse: got %0d expected 1", illegal_hi); else n_pass++;
        n_checks++; if (fetch_cyc[2] - fetch_cyc[1] !== 2) $display("FAIL funct_next: got %0d expected 2", fetch_cyc[2] - fetch_cyc[1]); else n_pass++;
    endtask

    task automatic test_random();
        bit ok;
        int exp_cy, a;
        logic [15:0] exp_tv;
        logic [5:0] fns[5];
        logic [4:0] rs, rt, rd;
        fns = '{6'h20, 6'h22, 6'h24, 6'h25, 6'h2A};
        for (int it = 0; it < 4; it++) begin
            clear_mem();
            a = 0;
            for (int i = 0; i < 20; i++) begin
                rs = 5'($urandom_range(0, 7));
                rt = 5'($urandom_range(0, 7));
                rd = 5'($urandom_range(0, 7));
                case ($urandom_range(0, 4))
                    0: mem[a] = enc_i(6'h08, rs, rt, 16'($urandom));
                    1: mem[a] = enc_r(rs, rt, rd, fns[$urandom_range(0, 4)]);
                    2: mem[a] = enc_i(6'h2B, 5'd0, rt, 16'(32'h800 + 4 * $urandom_range(0, 7)));
                    3: mem[a] = enc_i(6'h23, 5'd0, rt, 16'(32'h800 + 4 * $urandom_range(0, 7)));
                    default: mem[a] = enc_i(6'h04, rs, rt, 16'd1);
                endcase
                a++;
            end
            for (int r = 1; r < 8; r++) begin
                mem[a] = enc_i(6'h2B, 5'd0, 5'(r), 16'(32'h840 + 4 * r));
                a++;
            end
            mem[a] = HALT;
            fetch_wait = $urandom_range(0, 2);
            data_wait  = $urandom_range(0, 2);
            data_base  = 32'h800;
            m_mem = mem;
            for (int r = 0; r < 32; r++) m_regs[r] = 32'h0;
            model_run(32'(4 * a), exp_cy, exp_tv);
            do_reset();
            run(32'(4 * a), 1, 3000, ok);
            n_checks++; if (!ok) $display("FAIL rnd_timeout: iter %0d got no halt fetch expected one", it); else n_pass++;
            n_checks++; if (fetch_cyc[a] - fetch_cyc[0] !== exp_cy) $display("FAIL rnd_cycles: iter %0d got %0d expected %0d", it, fetch_cyc[a] - fetch_cyc[0], exp_cy); else n_pass++;
            n_checks++; if (test_value !== exp_tv) $display("FAIL rnd_tv: iter %0d got %h expected %h", it, test_value, exp_tv); else n_pass++;
            n_checks++; if (stab_err !== 0) $display("FAIL rnd_stable: iter %0d got %0d expected 0", it, stab_err); else n_pass++;
            for (int w = 512; w < 536; w++) begin
                n_checks++;
                if (mem[w] !== m_mem[w]) $display("FAIL rnd_mem: iter %0d word %0d got %h expected %h", it, w, mem[w], m_mem[w]);
                else n_pass++;
            end
        end
    endtask

    initial begin
        reset = 1'b0;
        mem_ready = 1'b0;
        mem_rdata = 32'h0;
        test_reset();
        test_addi_add();
        test_mem_wait();
        test_branch_jump();
        test_slt_zero();
        test_illegal();
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule

// File: doc/mips_multicycle.md
# mips_multicycle

Multicycle MIPS-subset core with a single shared instruction/data memory port and a ready/request handshake.
- Next generation of the single-cycle processor top: one ALU, one memory port, and an FSM that sequences each instruction over 3–5 cycles.
- Memory wait states are supported through the handshake.
- Sits between the board-level test harness and a unified memory model; `test_value` exposes one architectural register for bring-up.

## Interface
Parameters:
- `RESET_PC`, `32'h0000_0000`: PC value loaded at reset.
- `ADDR_W`, `32`: width of `mem_addr`. Byte address is `PC[ADDR_W-1:0]`, or ALU result for loads/stores.
- `TEST_REG`, `2`: register index whose low 16 bits drive `test_value`.

Ports:
- `clk` in 1: rising-edge clock.
- `reset` in 1: asynchronous, active-low reset.
- `mem_req` out 1: memory transfer requested.
- `mem_we` out 1: 1 = write, 0 = read. Valid with `mem_req`.
- `mem_addr` out `ADDR_W`: byte address.
- `mem_wdata` out 32: store data.
- `mem_ready` in 1: transfer completes in a cycle where `mem_req && mem_ready`.
- `mem_rdata` in 32: read data. Sampled at the completing edge.
- `illegal_op` out 1: one-cycle pulse in DECODE for an unsupported opcode or funct.
- `test_value` out 16: `regs[TEST_REG][15:0]`.

## Operation
Supported instructions:
- R-type: `add`, `sub`, `and`, `or`, `slt` (funct 20/22/24/25/2A hex).
- `lw` (23), `sw` (2B), `beq` (04), `addi` (08), `j` (02).

Datapath:
- Internal registers: PC, IR, MDR, A, B, ALUOut.
- Register file: 32×32, two read ports and one write port; `$0` reads 0 and writes to it are discarded.
- ALU arithmetic is 32-bit two's complement, overflow ignored.
- `slt` is a signed compare.
- Immediates are sign-extended.

FSM states and transitions:
- IDLE → FETCH.
- FETCH: `mem_req=1`, `mem_we=0`, `mem_addr=PC`. Holds until `mem_ready`; on completion IR←`mem_rdata`, PC←PC+4, then → DECODE.
- DECODE: A←rs, B←rt, ALUOut←PC+(signimm<<2). Next state by opcode: MEMADR (`lw`/`sw`), EXEC (R), BRANCH (`beq`), ADDIEX, JUMP. Illegal opcode or funct: pulse `illegal_op`, → FETCH (executes as NOP).
- MEMADR: ALUOut←A+signimm; → MEMRD (`lw`) or MEMWR (`sw`).
- MEMRD: read request at ALUOut. On `mem_ready`, MDR←`mem_rdata`, → MEMWB.
- MEMWB: rt←MDR; → FETCH.
- MEMWR: `mem_we=1`, `mem_wdata=B`, address ALUOut. On `mem_ready`, → FETCH.
- EXEC: ALUOut←A op B; → ALUWB.
- ALUWB: rd←ALUOut; → FETCH.
- ADDIEX: ALUOut←A+signimm; → ADDIWB.
- ADDIWB: rt←ALUOut; → FETCH.
- BRANCH: if A==B, PC←ALUOut; → FETCH.
- JUMP: PC←{PC[31:28], IR[25:0], 2'b00}; → FETCH.

Handshake rules:
- `mem_addr`, `mem_we` and `mem_wdata` stay stable while `mem_req` is high and `mem_ready` is low.
- `mem_req` is a combinational decode of the state and is 0 in all other states.
- `mem_ready` is ignored when `mem_req`=0.

Boundary conditions:
- Zero-wait memory (`mem_ready` tied 1) is legal.
- PC wraps modulo 2^32.
- A `beq` whose target equals its own address loops forever (legal).
- Writes to `$0` are silently dropped; `illegal_op` is not raised.

## Timing
Reset values (reset low, asynchronous):
- State IDLE; PC=`RESET_PC`; IR, MDR, A, B, ALUOut and all registers = 0.
- `mem_req`=0, `mem_we`=0, `mem_addr`=`RESET_PC[ADDR_W-1:0]`, `mem_wdata`=0, `illegal_op`=0, `test_value`=0.

Reset during a memory transfer:
- `mem_req` drops immediately and the transfer is abandoned.
- The memory model must tolerate the dropped request.

First fetch request is asserted in the first cycle after reset deasserts plus one IDLE cycle.

Cycles per instruction with zero-wait memory: `lw` 5, `sw` 4, R-type 4, `addi` 4, `beq` 3, `j` 3. Each memory wait cycle adds 1.

Register write-back is visible to the DECODE of the next instruction; there is no hazard logic (not needed in a multicycle design).

`test_value` updates the cycle after the write-back edge.

## Configuration
- `MIPS_MC_BNE_EN` defined:
  - Opcode 05 (`bne`) is decoded to BRANCH with an inverted compare: PC←ALUOut if A≠B.
  - 3 cycles.
- `MIPS_MC_BNE_EN` undefined:
  - Opcode 05 is illegal: `illegal_op` pulses and the instruction executes as NOP.

## Test plan
- Reset mid-FETCH with `mem_ready` held low → `mem_req` falls asynchronously; after release, IDLE for one cycle then FETCH at `RESET_PC`.
- `addi $2,$0,5`; `addi $3,$0,7`; `add $2,$2,$3` with zero-wait memory → `test_value`=12 after exactly 12 cycles from first FETCH.
- `sw $2,0x40($0)` then `lw $4,0x40($0)`, `mem_ready` low for 2 cycles per transfer → write seen with addr 0x40, data 12, `mem_we`=1 held stable; `$4`=12; `lw` takes 7 cycles.
- `beq $0,$0,-1` → PC returns to the `beq` address every 3 cycles. `j 0x100` → next fetch address 0x400.
- `slt $2,$5,$6` with `$5`=0xFFFFFFFF, `$6`=1 → `test_value`=1. `add $0,$5,$6` → `$0` stays 0.
- Opcode 05 with A≠B → branch taken if `MIPS_MC_BNE_EN` is defined; otherwise `illegal_op` pulses for one cycle in DECODE and the next fetch is at PC+4.
